// File: rtl/kem_phase_seq_pkg.sv
// Shared definitions for the ROLLO decapsulation phase sequencer.
//   - M / N       : field extension degree and code length used to size
//                   datapath words (memory data width defaults to 2*M)
//   - ST_*        : 3-bit FSM state encoding of the sequencer
//   - clog2()     : ceiling log2 for parameter-derived widths
package kem_phase_seq_pkg;

    localparam int M = 8;
    localparam int N = 47;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LAUNCH = 3'd1;
    localparam logic [2:0] ST_WAIT   = 3'd2;
    localparam logic [2:0] ST_DRAIN  = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;
    localparam logic [2:0] ST_ERR    = 3'd5;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/kem_phase_seq_port_pipe.sv
// DEPTH-stage register chain carrying the arbitrated memory port word
// (write enables, addresses and write data of both RAM ports).
//   clk  : clock
//   srst : synchronous active-high clear of every stage
//   din  : word from the phase select mux
//   dout : word delayed by DEPTH cycles
module kem_phase_seq_port_pipe #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             srst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic [WIDTH-1:0] q_reg;
            if (gi == 0) begin : g_head
                always_ff @(posedge clk) begin
                    if (srst) q_reg <= '0;
                    else      q_reg <= din;
                end
            end else begin : g_tail
                always_ff @(posedge clk) begin
                    if (srst) q_reg <= '0;
                    else      q_reg <= g_stage[gi-1].q_reg;
                end
            end
        end
    endgenerate

    assign dout = g_stage[DEPTH-1].q_reg;

endmodule

// File: rtl/kem_phase_seq.sv
// Phase sequencer and shared-memory port arbiter for ROLLO decapsulation.
// Launches enabled sub-engines in index order through start/done pulses,
// drains the memory pipeline between phases, aborts on a per-phase
// watchdog, and routes the active engine's A/B ports onto one RAM.
//   clk, rst_b            : clock, synchronous active-high reset
//   start, mode_mask      : run request (IDLE only) and phase enable bits
//   timeout_lim           : WAIT cycle limit per phase, 0 = no watchdog
//   finish, error, status : end-of-run pulse, sticky timeout, selected phase+1
//   ph_start, ph_done     : per-phase launch / completion pulses
//   ph_addr*/we*/di*      : per-phase RAM port requests, phase i at slot i
//   mem_addr*/we*/di*     : arbitrated RAM ports, DELAY_RD registers deep
module kem_phase_seq
    import kem_phase_seq_pkg::*;
#(
    parameter int NPH      = 4,
    parameter int AW       = 8,
    parameter int DW       = 2 * M,
    parameter int DELAY_RD = 2,
    parameter int TO_W     = 20
) (
    input  logic                         clk,
    input  logic                         rst_b,
    input  logic                         start,
    input  logic [NPH-1:0]               mode_mask,
    input  logic [TO_W-1:0]              timeout_lim,
    output logic                         finish,
    output logic                         error,
    output logic [clog2(NPH+1)-1:0]      status,
    output logic [NPH-1:0]               ph_start,
    input  logic [NPH-1:0]               ph_done,
    input  logic [NPH*AW-1:0]            ph_addra,
    input  logic [NPH*AW-1:0]            ph_addrb,
    input  logic [NPH-1:0]               ph_wea,
    input  logic [NPH-1:0]               ph_web,
    input  logic [NPH*DW-1:0]            ph_dia,
    input  logic [NPH*DW-1:0]            ph_dib,
    output logic [AW-1:0]                mem_addra,
    output logic [AW-1:0]                mem_addrb,
    output logic                         mem_wea,
    output logic                         mem_web,
    output logic [DW-1:0]                mem_dia,
    output logic [DW-1:0]                mem_dib
);

    localparam int IW  = (NPH > 1) ? clog2(NPH) : 1;
    localparam int SW  = clog2(NPH + 1);
    localparam int DCW = clog2(DELAY_RD) + 1;
    localparam int PW  = 2 * AW + 2 * DW + 2;

    logic [2:0]      state_reg, state_next;
    logic [IW-1:0]   cur_reg, cur_next;
    logic [NPH-1:0]  mask_reg, mask_next;
    logic [TO_W-1:0] wd_cnt_reg, wd_cnt_next;
    logic [DCW-1:0]  drain_cnt_reg, drain_cnt_next;
    logic            error_reg, error_next;

    logic [IW-1:0]   first_idx;
    logic [IW-1:0]   next_idx;
    logic            next_found;
    logic            active;
    logic [PW-1:0]   sel_word;
    logic [PW-1:0]   mem_word;

    // Priority encoders: lowest set bit of the incoming mask, and lowest
    // set bit of the latched mask strictly above the current phase.
    // Scanning downward lets the lowest matching index win.
    always_comb begin
        first_idx  = '0;
        next_idx   = '0;
        next_found = 1'b0;
        for (int i = NPH - 1; i >= 0; i--) begin
            if (mode_mask[i]) first_idx = IW'(i);
            if (mask_reg[i] && (IW'(i) > cur_reg)) begin
                next_found = 1'b1;
                next_idx   = IW'(i);
            end
        end
    end

    always_comb begin
        state_next     = state_reg;
        cur_next       = cur_reg;
        mask_next      = mask_reg;
        wd_cnt_next    = wd_cnt_reg;
        drain_cnt_next = drain_cnt_reg;
        error_next     = error_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    mask_next  = mode_mask;
                    error_next = 1'b0;
                    if (|mode_mask) begin
                        state_next = ST_LAUNCH;
                        cur_next   = first_idx;
                    end else begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_LAUNCH: begin
                wd_cnt_next = '0;
                state_next  = ST_WAIT;
            end
            ST_WAIT: begin
                // Completion wins over a timeout landing in the same cycle.
                if (ph_done[cur_reg]) begin
                    state_next     = ST_DRAIN;
                    drain_cnt_next = '0;
                end else if ((timeout_lim != '0) &&
                             (wd_cnt_reg == timeout_lim - TO_W'(1))) begin
                    state_next = ST_ERR;
                    error_next = 1'b1;
                end else begin
                    wd_cnt_next = wd_cnt_reg + TO_W'(1);
                end
            end
            ST_DRAIN: begin
                // Let the last writes of this phase clear the port pipe
                // before the next engine is launched.
                if (drain_cnt_reg == DCW'(DELAY_RD - 1)) begin
                    if (next_found) begin
                        state_next = ST_LAUNCH;
                        cur_next   = next_idx;
                    end else begin
                        state_next = ST_DONE;
                    end
                end else begin
                    drain_cnt_next = drain_cnt_reg + DCW'(1);
                end
            end
            ST_DONE:  state_next = ST_IDLE;
            ST_ERR:   state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_b) begin
            state_reg     <= ST_IDLE;
            cur_reg       <= '0;
            mask_reg      <= '0;
            wd_cnt_reg    <= '0;
            drain_cnt_reg <= '0;
            error_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cur_reg       <= cur_next;
            mask_reg      <= mask_next;
            wd_cnt_reg    <= wd_cnt_next;
            drain_cnt_reg <= drain_cnt_next;
            error_reg     <= error_next;
        end
    end

    assign active = (state_reg == ST_LAUNCH) || (state_reg == ST_WAIT) ||
                    (state_reg == ST_DRAIN);
    assign finish = (state_reg == ST_DONE) || (state_reg == ST_ERR);
    assign error  = error_reg;
    assign status = active ? (SW'(cur_reg) + SW'(1)) : '0;

    genvar gi;
    generate
        for (gi = 0; gi < NPH; gi++) begin : g_start
            assign ph_start[gi] = (state_reg == ST_LAUNCH) && (cur_reg == IW'(gi));
        end
    endgenerate

    // Only the selected phase is forwarded; with no phase selected the
    // port word is all zero so nothing can write the RAM.
    always_comb begin
        sel_word = '0;
        if (active) begin
            sel_word = {ph_wea[cur_reg], ph_web[cur_reg],
                        ph_addra[cur_reg*AW +: AW], ph_addrb[cur_reg*AW +: AW],
                        ph_dia[cur_reg*DW +: DW], ph_dib[cur_reg*DW +: DW]};
        end
    end

    kem_phase_seq_port_pipe #(
        .WIDTH (PW),
        .DEPTH (DELAY_RD)
    ) u_port_pipe (
        .clk  (clk),
        .srst (rst_b),
        .din  (sel_word),
        .dout (mem_word)
    );

    assign {mem_wea, mem_web, mem_addra, mem_addrb, mem_dia, mem_dib} = mem_word;

endmodule

// File: tb/tb_kem_phase_seq.sv
module tb_kem_phase_seq;

    localparam int NPH = 4;
    localparam int AW  = 8;
    localparam int DW  = 16;
    localparam int DRD = 2;
    localparam int TOW = 20;

    logic              clk;
    logic              rst_b;
    logic              start;
    logic [NPH-1:0]    mode_mask;
    logic [TOW-1:0]    timeout_lim;
    logic              finish;
    logic              error;
    logic [2:0]        status;
    logic [NPH-1:0]    ph_start;
    logic [NPH-1:0]    ph_done;
    logic [NPH*AW-1:0] ph_addra, ph_addrb;
    logic [NPH-1:0]    ph_wea, ph_web;
    logic [NPH*DW-1:0] ph_dia, ph_dib;
    logic [AW-1:0]     mem_addra, mem_addrb;
    logic              mem_wea, mem_web;
    logic [DW-1:0]     mem_dia, mem_dib;

    int vec_cnt  = 0;
    int miss_cnt = 0;
    logic [NPH-1:0] seen_start;
    int wea_cnt;
    int web_cnt;

    kem_phase_seq #(
        .NPH(NPH), .AW(AW), .DW(DW), .DELAY_RD(DRD), .TO_W(TOW)
    ) dut (
        .clk(clk), .rst_b(rst_b), .start(start), .mode_mask(mode_mask),
        .timeout_lim(timeout_lim), .finish(finish), .error(error),
        .status(status), .ph_start(ph_start), .ph_done(ph_done),
        .ph_addra(ph_addra), .ph_addrb(ph_addrb), .ph_wea(ph_wea),
        .ph_web(ph_web), .ph_dia(ph_dia), .ph_dib(ph_dib),
        .mem_addra(mem_addra), .mem_addrb(mem_addrb), .mem_wea(mem_wea),
        .mem_web(mem_web), .mem_dia(mem_dia), .mem_dib(mem_dib)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Activity observed between edges, away from the active edge.
    always @(negedge clk) begin
        seen_start = seen_start | ph_start;
        if (mem_wea === 1'b1) wea_cnt = wea_cnt + 1;
        if (mem_web === 1'b1) web_cnt = web_cnt + 1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_b = 1'b1;
        tick;
        tick;
        vec_cnt++; if (finish !== 1'b0) begin miss_cnt++; $display("FAIL reset_finish: got %b expected 0", finish); end
        vec_cnt++; if (error !== 1'b0) begin miss_cnt++; $display("FAIL reset_error: got %b expected 0", error); end
        vec_cnt++; if (status !== 3'd0) begin miss_cnt++; $display("FAIL reset_status: got %0d expected 0", status); end
        vec_cnt++; if (ph_start !== 4'b0000) begin miss_cnt++; $display("FAIL reset_ph_start: got %b expected 0000", ph_start); end
        vec_cnt++; if ({mem_wea, mem_web, mem_addra, mem_dia} !== 26'd0) begin miss_cnt++; $display("FAIL reset_mem: got we=%b%b addra=%h dia=%h expected all 0", mem_wea, mem_web, mem_addra, mem_dia); end
        rst_b = 1'b0;
        tick;
        vec_cnt++; if (status !== 3'd0) begin miss_cnt++; $display("FAIL reset_idle_status: got %0d expected 0", status); end
        $display("reset: outputs cleared, idle");
    endtask

    task automatic test_all_phases;
        logic [NPH-1:0] exp_start;
        seen_start = '0;
        start = 1'b1; mode_mask = 4'b1111;
        tick;
        start = 1'b0; mode_mask = '0;
        for (int p = 0; p < NPH; p++) begin
            exp_start = 4'b0001 << p;
            vec_cnt++; if (ph_start !== exp_start) begin miss_cnt++; $display("FAIL all_ph_start%0d: got %b expected %b", p, ph_start, exp_start); end
            vec_cnt++; if (status !== 3'(p + 1)) begin miss_cnt++; $display("FAIL all_status%0d: got %0d expected %0d", p, status, p + 1); end
            tick; tick; tick; tick;
            ph_done = exp_start;
            tick;
            ph_done = '0;
            vec_cnt++; if (status !== 3'(p + 1)) begin miss_cnt++; $display("FAIL all_drain_status%0d: got %0d expected %0d", p, status, p + 1); end
            tick;
            tick;
            $display("all_phases: phase %0d launched and completed", p);
        end
        vec_cnt++; if (finish !== 1'b1) begin miss_cnt++; $display("FAIL all_finish: got %b expected 1", finish); end
        vec_cnt++; if (error !== 1'b0) begin miss_cnt++; $display("FAIL all_error: got %b expected 0", error); end
        vec_cnt++; if (status !== 3'd0) begin miss_cnt++; $display("FAIL all_end_status: got %0d expected 0", status); end
        tick;
        vec_cnt++; if (finish !== 1'b0) begin miss_cnt++; $display("FAIL all_finish_pulse: got %b expected 0", finish); end
        vec_cnt++; if (seen_start !== 4'b1111) begin miss_cnt++; $display("FAIL all_seen_start: got %b expected 1111", seen_start); end
    endtask

    task automatic test_sparse_mask;
        seen_start = '0;
        start = 1'b1; mode_mask = 4'b1010;
        tick;
        start = 1'b0; mode_mask = '0;
        vec_cnt++; if (ph_start !== 4'b0010) begin miss_cnt++; $display("FAIL sparse_ph_start1: got %b expected 0010", ph_start); end
        vec_cnt++; if (status !== 3'd2) begin miss_cnt++; $display("FAIL sparse_status1: got %0d expected 2", status); end
        tick;
        // Foreign done plus a start request mid-run: both must be ignored.
        ph_done = 4'b0001; start = 1'b1; mode_mask = 4'b0001;
        tick;
        ph_done = '0; start = 1'b0; mode_mask = '0;
        vec_cnt++; if (status !== 3'd2) begin miss_cnt++; $display("FAIL sparse_foreign_done: got status %0d expected 2", status); end
        tick; tick;
        ph_done = 4'b0010;
        tick;
        ph_done = '0;
        tick;
        tick;
        vec_cnt++; if (ph_start !== 4'b1000) begin miss_cnt++; $display("FAIL sparse_ph_start3: got %b expected 1000", ph_start); end
        vec_cnt++; if (status !== 3'd4) begin miss_cnt++; $display("FAIL sparse_status3: got %0d expected 4", status); end
        tick; tick;
        ph_done = 4'b1000;
        tick;
        ph_done = '0;
        tick;
        tick;
        vec_cnt++; if (finish !== 1'b1) begin miss_cnt++; $display("FAIL sparse_finish: got %b expected 1", finish); end
        tick;
        vec_cnt++; if (seen_start !== 4'b1010) begin miss_cnt++; $display("FAIL sparse_seen_start: got %b expected 1010", seen_start); end
        $display("sparse_mask: phases 1 and 3 only");
    endtask

    task automatic test_empty_mask;
        seen_start = '0; wea_cnt = 0; web_cnt = 0;
        ph_wea = '1; ph_web = '1;
        start = 1'b1; mode_mask = 4'b0000;
        tick;
        start = 1'b0;
        vec_cnt++; if (finish !== 1'b1) begin miss_cnt++; $display("FAIL empty_finish: got %b expected 1", finish); end
        vec_cnt++; if (status !== 3'd0) begin miss_cnt++; $display("FAIL empty_status: got %0d expected 0", status); end
        tick;
        vec_cnt++; if (finish !== 1'b0) begin miss_cnt++; $display("FAIL empty_finish_pulse: got %b expected 0", finish); end
        tick;
        vec_cnt++; if (seen_start !== 4'b0000) begin miss_cnt++; $display("FAIL empty_seen_start: got %b expected 0000", seen_start); end
        vec_cnt++; if (wea_cnt + web_cnt != 0) begin miss_cnt++; $display("FAIL empty_mem_we: got %0d write cycles expected 0", wea_cnt + web_cnt); end
        ph_wea = '0; ph_web = '0;
        $display("empty_mask: immediate finish, no launch");
    endtask

    task automatic test_timeout;
        timeout_lim = 20'd16;
        start = 1'b1; mode_mask = 4'b0001;
        tick;
        start = 1'b0; mode_mask = '0;
        vec_cnt++; if (ph_start !== 4'b0001) begin miss_cnt++; $display("FAIL to_ph_start: got %b expected 0001", ph_start); end
        tick;                                   // first WAIT cycle
        for (int i = 0; i < 15; i++) tick;
        vec_cnt++; if ({status, finish, error} !== {3'd1, 1'b0, 1'b0}) begin miss_cnt++; $display("FAIL to_before: got status=%0d finish=%b error=%b expected 1 0 0", status, finish, error); end
        tick;
        vec_cnt++; if ({finish, error} !== 2'b11) begin miss_cnt++; $display("FAIL to_fire: got finish=%b error=%b expected 1 1", finish, error); end
        vec_cnt++; if (status !== 3'd0) begin miss_cnt++; $display("FAIL to_status: got %0d expected 0", status); end
        tick;
        vec_cnt++; if ({finish, error} !== 2'b01) begin miss_cnt++; $display("FAIL to_sticky: got finish=%b error=%b expected 0 1", finish, error); end
        timeout_lim = '0;
        start = 1'b1; mode_mask = 4'b0000;
        tick;
        start = 1'b0;
        vec_cnt++; if ({finish, error} !== 2'b10) begin miss_cnt++; $display("FAIL to_clear: got finish=%b error=%b expected 1 0", finish, error); end
        tick;
        $display("timeout: error after 16 WAIT cycles, cleared by next start");
    endtask

    task automatic test_port_route;
        wea_cnt = 0; web_cnt = 0;
        ph_wea = 4'b1011; ph_web = 4'b1011;
        ph_addra = {8'h44, 8'h33, 8'h22, 8'h11};
        ph_addrb = {8'hA4, 8'hA3, 8'hA2, 8'hA1};
        ph_dia = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        ph_dib = {16'hB444, 16'hB333, 16'hB222, 16'hB111};
        start = 1'b1; mode_mask = 4'b0100;
        tick;
        start = 1'b0; mode_mask = '0;
        vec_cnt++; if (status !== 3'd3) begin miss_cnt++; $display("FAIL route_status: got %0d expected 3", status); end
        tick; tick;
        ph_wea[2] = 1'b1; ph_addra[2*AW +: AW] = 8'h3C; ph_dia[2*DW +: DW] = 16'hBEEF;
        tick;
        ph_wea[2] = 1'b0; ph_addra[2*AW +: AW] = 8'h33; ph_dia[2*DW +: DW] = 16'h3333;
        vec_cnt++; if (mem_wea !== 1'b0) begin miss_cnt++; $display("FAIL route_early: got mem_wea=%b expected 0", mem_wea); end
        tick;
        vec_cnt++; if ({mem_wea, mem_addra, mem_dia} !== {1'b1, 8'h3C, 16'hBEEF}) begin miss_cnt++; $display("FAIL route_write: got we=%b addra=%h dia=%h expected 1 3c beef", mem_wea, mem_addra, mem_dia); end
        tick;
        vec_cnt++; if (mem_wea !== 1'b0) begin miss_cnt++; $display("FAIL route_after: got mem_wea=%b expected 0", mem_wea); end
        ph_done = 4'b0100;
        tick;
        ph_done = '0;
        tick;
        tick;
        vec_cnt++; if (finish !== 1'b1) begin miss_cnt++; $display("FAIL route_finish: got %b expected 1", finish); end
        tick; tick;
        vec_cnt++; if (wea_cnt != 1) begin miss_cnt++; $display("FAIL route_wea_count: got %0d expected 1", wea_cnt); end
        vec_cnt++; if (web_cnt != 0) begin miss_cnt++; $display("FAIL route_web_count: got %0d expected 0", web_cnt); end
        ph_wea = '0; ph_web = '0; ph_addra = '0; ph_addrb = '0; ph_dia = '0; ph_dib = '0;
        $display("port_route: single write of phase 2 reached the RAM");
    endtask

    task automatic test_reset_mid_run;
        start = 1'b1; mode_mask = 4'b1011;
        tick;
        start = 1'b0; mode_mask = '0;
        tick; tick;
        ph_done = 4'b0001;
        tick;
        ph_done = '0;
        tick;
        tick;
        vec_cnt++; if ({ph_start, status} !== {4'b0010, 3'd2}) begin miss_cnt++; $display("FAIL mid_launch1: got ph_start=%b status=%0d expected 0010 2", ph_start, status); end
        tick;
        ph_wea[1] = 1'b1; ph_addra[AW +: AW] = 8'h77;
        tick;
        rst_b = 1'b1; ph_wea = '0; ph_addra = '0;
        tick;
        vec_cnt++; if ({finish, error, status, ph_start} !== 9'd0) begin miss_cnt++; $display("FAIL mid_reset_ctl: got finish=%b error=%b status=%0d ph_start=%b expected all 0", finish, error, status, ph_start); end
        vec_cnt++; if ({mem_wea, mem_addra} !== 9'd0) begin miss_cnt++; $display("FAIL mid_reset_mem: got we=%b addra=%h expected 0 00", mem_wea, mem_addra); end
        rst_b = 1'b0;
        tick;
        vec_cnt++; if ({mem_wea, status} !== 4'd0) begin miss_cnt++; $display("FAIL mid_inflight: got we=%b status=%0d expected 0 0", mem_wea, status); end
        start = 1'b1; mode_mask = 4'b1011;
        tick;
        start = 1'b0; mode_mask = '0;
        vec_cnt++; if ({ph_start, status} !== {4'b0001, 3'd1}) begin miss_cnt++; $display("FAIL mid_restart: got ph_start=%b status=%0d expected 0001 1", ph_start, status); end
        rst_b = 1'b1;
        tick;
        rst_b = 1'b0;
        tick;
        $display("reset_mid_run: run aborted, fresh start from phase 0");
    endtask

    initial begin
        rst_b = 1'b1; start = 1'b0; mode_mask = '0; timeout_lim = '0;
        ph_done = '0; ph_addra = '0; ph_addrb = '0; ph_wea = '0; ph_web = '0;
        ph_dia = '0; ph_dib = '0;
        seen_start = '0; wea_cnt = 0; web_cnt = 0;
        test_reset;
        test_all_phases;
        test_sparse_mask;
        test_empty_mask;
        test_timeout;
        test_port_route;
        test_reset_mid_run;
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
